// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    FILL
  } dcache_state_t;

  // Tag storage is sized for the widest supported address; unused upper bits stay zero.
  localparam int MAX_TAG_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } line_meta_t;

  function automatic int log2c(input int v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set metadata and data block, combinational lookup at idx,
// byte update for write hits and whole-block fill from the miss path.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int IDX_W = 2,
  parameter int OFF_W = 2,
  parameter int BLK_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag_in,
  output logic             hit,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag,
  output logic [BLK_W-1:0] blk,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [7:0]       wr_byte,
  input  logic             fill_en,
  input  logic [BLK_W-1:0] fill_blk
);

  localparam int SETS = 1 << IDX_W;

  line_meta_t       meta_q [SETS];
  line_meta_t       meta_d [SETS];
  logic [BLK_W-1:0] data_q [SETS];
  logic [BLK_W-1:0] data_d [SETS];
  line_meta_t       cur;

  assign cur   = meta_q[idx];
  assign valid = cur.valid;
  assign dirty = cur.dirty;
  assign tag   = cur.tag[TAG_W-1:0];
  assign hit   = cur.valid && (cur.tag == MAX_TAG_W'(tag_in));
  assign blk   = data_q[idx];

  always_comb begin
    meta_d = meta_q;
    data_d = data_q;
    if (fill_en) begin
      meta_d[idx] = '{valid: 1'b1, dirty: 1'b0, tag: MAX_TAG_W'(tag_in)};
      data_d[idx] = fill_blk;
    end else if (wr_en) begin
      meta_d[idx].dirty = 1'b1;
      data_d[idx][{wr_off, 3'b000} +: 8] = wr_byte;
    end
  end

  // Only metadata needs clearing; stale data is unreachable once valid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) meta_q[s] <= '0;
    end else begin
      meta_q <= meta_d;
    end
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate 1/2-way data cache with per-set LRU and block-wide memory port.
// Define DCACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  localparam int OFF_W = log2c(WORDS),
  localparam int IDX_W = log2c(SETS),
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W,
  localparam int BLK_W = 8 * WORDS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   read,
  input  logic                   write,
  input  logic [ADDR_W-1:0]      address,
  input  logic [7:0]             writedata,
  output logic [7:0]             readdata,
  output logic                   busywait,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [TAG_W+IDX_W-1:0] mem_address,
  output logic [BLK_W-1:0]       mem_writedata,
  input  logic [BLK_W-1:0]       mem_readdata,
  input  logic                   mem_busywait
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] cpu_idx;
  logic [OFF_W-1:0] cpu_off;
  assign {cpu_tag, cpu_idx, cpu_off} = address;

  dcache_state_t    state_q, state_d;
  logic             victim_q, victim_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] fill_blk_q, fill_blk_d;
  logic [SETS-1:0]  lru_q, lru_d;

  logic [IDX_W-1:0] lk_idx;
  logic [WAYS-1:0]  way_hit, way_valid, way_dirty, way_wr, way_fill;
  logic [TAG_W-1:0] way_tag [WAYS];
  logic [BLK_W-1:0] way_blk [WAYS];
  logic             access, hit, hit_way, victim;
  logic [BLK_W-1:0] hit_blk;

  assign access = read | write;
  assign lk_idx = (state_q == IDLE) ? cpu_idx : idx_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .BLK_W(BLK_W)
    ) u_way (
      .clock   (clock),
      .reset   (reset),
      .idx     (lk_idx),
      .tag_in  (cpu_tag),
      .hit     (way_hit[w]),
      .valid   (way_valid[w]),
      .dirty   (way_dirty[w]),
      .tag     (way_tag[w]),
      .blk     (way_blk[w]),
      .wr_en   (way_wr[w]),
      .wr_off  (cpu_off),
      .wr_byte (writedata),
      .fill_en (way_fill[w]),
      .fill_blk(fill_blk_q)
    );
  end

  // Descending loops leave the lowest-numbered matching way selected.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    hit_blk = '0;
    victim  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_way = 1'(w);
        hit_blk = way_blk[w];
      end
    end
    if (WAYS > 1 && (&way_valid)) begin
      victim = lru_q[lk_idx];
    end else begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!way_valid[w]) victim = 1'(w);
      end
    end
  end

  assign readdata = hit_blk[{cpu_off, 3'b000} +: 8];
  assign busywait = access && !(state_q == IDLE && hit);

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    idx_d         = idx_q;
    fill_blk_d    = fill_blk_q;
    lru_d         = lru_q;
    way_wr        = '0;
    way_fill      = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      IDLE: begin
        if (access && hit) begin
          if (write) way_wr[hit_way] = 1'b1;
          if (WAYS > 1) lru_d[cpu_idx] = ~hit_way;
        end else if (access) begin
          victim_d = victim;
          idx_d    = cpu_idx;
          state_d  = (way_valid[victim] && way_dirty[victim]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {way_tag[victim_q], idx_q};
        mem_writedata = way_blk[victim_q];
        if (!mem_busywait) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = {cpu_tag, idx_q};
        if (!mem_busywait) begin
          state_d    = FILL;
          fill_blk_d = mem_readdata;
        end
      end
      FILL: begin
        way_fill[victim_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      victim_q   <= 1'b0;
      idx_q      <= '0;
      fill_blk_q <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      idx_q      <= idx_d;
      fill_blk_q <= fill_blk_d;
      lru_q      <= lru_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // missed_q marks an access that already counted as a miss so its final hit is not counted.
  logic        missed_q, missed_d;
  logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    missed_d     = missed_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && access) begin
      if (hit) begin
        missed_d = 1'b0;
        if (!missed_q && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        missed_d = 1'b1;
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      missed_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      missed_q     <= missed_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed vector table, reset-mid-miss sequence, and random
// accesses checked against a flat-memory plus per-set recency-list model.
module tb_dcache_assoc;

  localparam int BUSY = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0;
  logic [7:0]  address = 8'h00, writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clock = ~clock;

  dcache_assoc dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Block memory: busy for BUSY cycles, then completes in the cycle busywait is low.
  logic [31:0] mem [64];
  logic        mem_init = 1'b0;
  int          mem_cnt = 0, wb_cnt = 0, mrd_cnt = 0;
  logic [5:0]  wb_addr = 6'h0, mrd_addr = 6'h0;
  logic [31:0] wb_data = 32'h0;

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt != BUSY);
  assign mem_readdata = mem[mem_address];

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int b = 0; b < 64; b++)
        mem[b] <= {8'h44 + 8'(b), 8'h33 + 8'(b), 8'h22 + 8'(b), 8'h11 + 8'(b)};
      mem_init <= 1'b1;
    end
    if (mem_read || mem_write) begin
      if (mem_cnt == BUSY) begin
        mem_cnt <= 0;
        if (mem_write) begin
          mem[mem_address] <= mem_writedata;
          wb_cnt  <= wb_cnt + 1;
          wb_addr <= mem_address;
          wb_data <= mem_writedata;
        end else begin
          mrd_cnt  <= mrd_cnt + 1;
          mrd_addr <= mem_address;
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           output int stall, output logic [7:0] rd,
                           output int nwb, output int nmrd);
    int wb0, mrd0;
    wb0 = wb_cnt;
    mrd0 = mrd_cnt;
    write = wr;
    read = !wr;
    address = a;
    writedata = d;
    stall = 0;
    @(negedge clock);
    while (busywait && stall < 200) begin
      @(negedge clock);
      stall++;
    end
    if (busywait) begin
      total++;
      bad++;
      $display("FAIL access_timeout: addr 0x%0h still busy after %0d cycles", a, stall);
    end
    rd = readdata;
    @(posedge clock);
    #1;
    read = 1'b0;
    write = 1'b0;
    nwb = wb_cnt - wb0;
    nmrd = mrd_cnt - mrd0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [7:0]  rd;
    int          stall;
    int          nwb;
    logic [5:0]  wba;
    logic [31:0] wbd;
    int          nmrd;
    logic [5:0]  mra;
  } vec_t;

  vec_t vt [11];

  initial begin
    int          stall, nwb, nmrd, n, pos, set, tg, v;
    logic [7:0]  rd, a, d;
    logic        wr, hit, ev_wb;
    logic [5:0]  ev_addr;
    logic [7:0]  gold [64];
    int          q [4][$];
    bit          dm [4][16];

    // Per block b, byte k of memory starts as 0x11*(k+1)+b.
    vt[0]  = '{1'b0, 8'h00, 8'h00, 8'h11, 8,  0, 6'h00, 32'h0,        1, 6'h00};
    vt[1]  = '{1'b0, 8'h01, 8'h00, 8'h22, 0,  0, 6'h00, 32'h0,        0, 6'h00};
    vt[2]  = '{1'b1, 8'h02, 8'hAA, 8'h00, 0,  0, 6'h00, 32'h0,        0, 6'h00};
    vt[3]  = '{1'b0, 8'h02, 8'h00, 8'hAA, 0,  0, 6'h00, 32'h0,        0, 6'h00};
    vt[4]  = '{1'b0, 8'h10, 8'h00, 8'h15, 8,  0, 6'h00, 32'h0,        1, 6'h04};
    vt[5]  = '{1'b0, 8'h00, 8'h00, 8'h11, 0,  0, 6'h00, 32'h0,        0, 6'h00};
    vt[6]  = '{1'b0, 8'h20, 8'h00, 8'h19, 8,  0, 6'h00, 32'h0,        1, 6'h08};
    vt[7]  = '{1'b0, 8'h00, 8'h00, 8'h11, 0,  0, 6'h00, 32'h0,        0, 6'h00};
    vt[8]  = '{1'b0, 8'h10, 8'h00, 8'h15, 8,  0, 6'h00, 32'h0,        1, 6'h04};
    vt[9]  = '{1'b0, 8'h20, 8'h00, 8'h19, 14, 1, 6'h00, 32'h44AA2211, 1, 6'h08};
    vt[10] = '{1'b0, 8'h02, 8'h00, 8'hAA, 8,  0, 6'h00, 32'h0,        1, 6'h00};

    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_writedata", mem_writedata, 32'h0);
    check("rst_busywait", 32'(busywait), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_access(vt[i].wr, vt[i].a, vt[i].d, stall, rd, nwb, nmrd);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].stall));
      if (!vt[i].wr) check($sformatf("vec%0d_readdata", i), 32'(rd), 32'(vt[i].rd));
      check($sformatf("vec%0d_wb_count", i), 32'(nwb), 32'(vt[i].nwb));
      check($sformatf("vec%0d_rd_count", i), 32'(nmrd), 32'(vt[i].nmrd));
      if (vt[i].nwb > 0) begin
        check($sformatf("vec%0d_wb_addr", i), 32'(wb_addr), 32'(vt[i].wba));
        check($sformatf("vec%0d_wb_data", i), wb_data, vt[i].wbd);
      end
      if (vt[i].nmrd > 0) check($sformatf("vec%0d_rd_addr", i), 32'(mrd_addr), 32'(vt[i].mra));
    end

    // Reset while the fetch for 0x30 is in flight.
    read = 1'b1;
    address = 8'h30;
    n = 0;
    while (!mem_read && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("alloc_reached", 32'(mem_read), 32'h1);
    reset = 1'b1;
    read = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_mem_read", 32'(mem_read), 32'h0);
    check("midrst_mem_write", 32'(mem_write), 32'h0);
    check("midrst_mem_address", 32'(mem_address), 32'h0);
    check("midrst_busywait", 32'(busywait), 32'h0);
    reset = 1'b0;
    do_access(1'b0, 8'h00, 8'h00, stall, rd, nwb, nmrd);
    check("post_rst_stall", 32'(stall), 32'd8);
    check("post_rst_readdata", 32'(rd), 32'h11);
    check("post_rst_rd_count", 32'(nmrd), 32'd1);

`ifdef DCACHE_PERF_CNT_EN
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("perf_rst_hits", 32'(hit_count), 32'h0);
    do_access(1'b0, 8'h00, 8'h00, stall, rd, nwb, nmrd);
    do_access(1'b0, 8'h01, 8'h00, stall, rd, nwb, nmrd);
    do_access(1'b1, 8'h02, 8'h5A, stall, rd, nwb, nmrd);
    do_access(1'b0, 8'h10, 8'h00, stall, rd, nwb, nmrd);
    do_access(1'b0, 8'h11, 8'h00, stall, rd, nwb, nmrd);
    check("perf_miss_count", 32'(miss_count), 32'd2);
    check("perf_hit_count", 32'(hit_count), 32'd3);
`endif

    // Random phase: cache empties, so the flat view equals backing memory.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 4; k++) gold[b*4+k] = mem[b][k*8 +: 8];
    for (int s = 0; s < 4; s++) begin
      q[s].delete();
      for (int t = 0; t < 16; t++) dm[s][t] = 1'b0;
    end

    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      set = int'(a[3:2]);
      tg = int'(a[7:4]);
      pos = -1;
      for (int j = 0; j < q[set].size(); j++) if (q[set][j] == tg) pos = j;
      hit = (pos >= 0);
      ev_wb = 1'b0;
      ev_addr = 6'h0;
      if (hit) begin
        q[set].delete(pos);
      end else if (q[set].size() == 2) begin
        v = q[set].pop_front();
        ev_wb = dm[set][v];
        dm[set][v] = 1'b0;
        ev_addr = 6'(v * 4 + set);
      end
      q[set].push_back(tg);

      do_access(wr, a, d, stall, rd, nwb, nmrd);
      check($sformatf("rnd%0d_stall", i), 32'(stall), hit ? 32'd0 : (ev_wb ? 32'd14 : 32'd8));
      if (!wr) check($sformatf("rnd%0d_readdata", i), 32'(rd), 32'(gold[a]));
      check($sformatf("rnd%0d_wb_count", i), 32'(nwb), 32'(ev_wb));
      check($sformatf("rnd%0d_rd_count", i), 32'(nmrd), hit ? 32'd0 : 32'd1);
      if (ev_wb) begin
        check($sformatf("rnd%0d_wb_addr", i), 32'(wb_addr), 32'(ev_addr));
        check($sformatf("rnd%0d_wb_data", i), wb_data,
              {gold[ev_addr*4+3], gold[ev_addr*4+2], gold[ev_addr*4+1], gold[ev_addr*4]});
      end
      if (!hit) check($sformatf("rnd%0d_rd_addr", i), 32'(mrd_addr), 32'(a[7:2]));
      if (wr) begin
        gold[a] = d;
        dm[set][tg] = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
